// File: rtl/phy_reg_free_list_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phy_reg_free_list_if                                            |
// | Brief    : Rename-side alloc/commit/flush bundle for the preg free list.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface phy_reg_free_list_if #(
  parameter int PHY_REG_NUM  = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
);
  localparam int c_PW    = $clog2(PHY_REG_NUM);
  localparam int c_DEPTH = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int c_CW    = $clog2(c_DEPTH) + 1;

  logic [ALLOC_WIDTH-1:0]             alloc_valid_i;
  logic                               alloc_ready_o;
  logic [ALLOC_WIDTH-1:0][c_PW-1:0]   alloc_preg_o;
  logic [COMMIT_WIDTH-1:0]            commit_valid_i;
  logic [COMMIT_WIDTH-1:0][c_PW-1:0]  commit_preg_i;
  logic                               flush_i;
  logic [c_CW-1:0]                    free_count_o;

  modport master (
    output alloc_valid_i, commit_valid_i, commit_preg_i, flush_i,
    input  alloc_ready_o, alloc_preg_o, free_count_o
  );

  modport slave (
    input  alloc_valid_i, commit_valid_i, commit_preg_i, flush_i,
    output alloc_ready_o, alloc_preg_o, free_count_o
  );
endinterface
`default_nettype wire

// File: rtl/phy_reg_free_list.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phy_reg_free_list                                               |
// | Brief    : Circular free list of physical registers with committed head    |
// |            so a flush restores all speculative grants in one cycle.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module phy_reg_free_list #(
  parameter int PHY_REG_NUM  = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  wire logic          clk,
  input  wire logic          a_rst_n,
  phy_reg_free_list_if.slave fl_if
);
  localparam int c_DEPTH = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int c_PW    = $clog2(PHY_REG_NUM);
  localparam int c_IW    = $clog2(c_DEPTH);
  localparam int c_PTR_W = c_IW + 1;

  logic [c_PW-1:0]    r_list [c_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_chead;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W-1:0] r_count;

  logic [c_PTR_W-1:0] w_head_nxt;
  logic [c_PTR_W-1:0] w_chead_nxt;
  logic [c_PTR_W-1:0] w_tail_nxt;
  logic [c_PTR_W-1:0] w_alloc_n;
  logic [c_PTR_W-1:0] w_commit_n;
  logic [c_IW-1:0]    w_alloc_off  [ALLOC_WIDTH];
  logic [c_IW-1:0]    w_commit_off [COMMIT_WIDTH];
  logic [c_IW-1:0]    w_rd_idx     [ALLOC_WIDTH];
  logic [c_IW-1:0]    w_wr_idx     [COMMIT_WIDTH];
  logic [c_PTR_W-1:0] w_inflight;
  logic               w_ready;
  logic               w_fire;

  // Exclusive prefix popcounts compact requests/returns onto consecutive slots.
  always_comb begin
    w_alloc_n = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      w_alloc_off[i] = w_alloc_n[c_IW-1:0];
      w_alloc_n      = w_alloc_n + c_PTR_W'(fl_if.alloc_valid_i[i]);
    end
  end

  always_comb begin
    w_commit_n = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      w_commit_off[j] = w_commit_n[c_IW-1:0];
      w_commit_n      = w_commit_n + c_PTR_W'(fl_if.commit_valid_i[j]);
    end
  end

  assign w_ready = (r_count >= c_PTR_W'(ALLOC_WIDTH)) && !fl_if.flush_i;
  assign w_fire  = w_ready && (|fl_if.alloc_valid_i);

  assign fl_if.alloc_ready_o = w_ready;
  assign fl_if.free_count_o  = r_count;

  generate
    for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_grant
      assign w_rd_idx[gi]           = r_head[c_IW-1:0] + w_alloc_off[gi];
      assign fl_if.alloc_preg_o[gi] = r_list[w_rd_idx[gi]];
    end
    for (genvar gj = 0; gj < COMMIT_WIDTH; gj++) begin : g_ret_idx
      assign w_wr_idx[gj] = r_tail[c_IW-1:0] + w_commit_off[gj];
    end
  endgenerate

  // Commit lands before flush, so a flush rewinds to the post-commit chead.
  always_comb begin
    w_tail_nxt  = r_tail + w_commit_n;
    w_chead_nxt = r_chead + w_commit_n;
    w_head_nxt  = r_head;
    if (fl_if.flush_i) begin
      w_head_nxt = w_chead_nxt;
    end else if (w_fire) begin
      w_head_nxt = r_head + w_alloc_n;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_head  <= '0;
      r_chead <= '0;
      r_tail  <= c_PTR_W'(c_DEPTH);
      r_count <= c_PTR_W'(c_DEPTH);
    end else begin
      r_head  <= w_head_nxt;
      r_chead <= w_chead_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_tail_nxt - w_head_nxt;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_list[i] <= c_PW'(ARCH_REG_NUM + i);
      end
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (fl_if.commit_valid_i[j]) begin
          r_list[w_wr_idx[j]] <= fl_if.commit_preg_i[j];
        end
      end
    end
  end

  assign w_inflight = r_head - r_chead;

  a_count_bound: assert property (@(posedge clk) disable iff (!a_rst_n)
    r_count <= c_PTR_W'(c_DEPTH));

  a_chead_behind_head: assert property (@(posedge clk) disable iff (!a_rst_n)
    w_inflight <= c_PTR_W'(c_DEPTH));
endmodule
`default_nettype wire

// File: tb/tb_phy_reg_free_list.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_phy_reg_free_list                                            |
// | Brief    : Scoreboard bench: driver queues expectations, monitor compares. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_phy_reg_free_list;
  localparam int PHY  = 64;
  localparam int ARCH = 32;
  localparam int AW   = 2;
  localparam int CW   = 2;

  logic clk     = 1'b0;
  logic a_rst_n = 1'b0;
  always #5 clk = ~clk;

  phy_reg_free_list_if #(.PHY_REG_NUM(PHY), .ARCH_REG_NUM(ARCH),
                         .ALLOC_WIDTH(AW), .COMMIT_WIDTH(CW)) u_if ();

  phy_reg_free_list #(.PHY_REG_NUM(PHY), .ARCH_REG_NUM(ARCH),
                      .ALLOC_WIDTH(AW), .COMMIT_WIDTH(CW)) u_dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .fl_if   (u_if.slave)
  );

  typedef struct packed {
    logic [15:0] tag;
    logic        rdy;
    logic [1:0]  chk_p;
    logic [5:0]  p1;
    logic [5:0]  p0;
    logic [5:0]  cnt;
  } exp_t;

  exp_t       exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         tag      = 0;

  // Queue-based reference: sq = granted but uncommitted, fq = free in grant order.
  logic [5:0] fq [$];
  logic [5:0] sq [$];
  logic [5:0] mapped [$];

  task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (step %0d): actual %0d required %0d", nm, t, act, req);
    end
  endtask

  // Monitor: compares queued expectations and tracks preg ownership from DUT traffic.
  logic       mown [PHY];
  logic [5:0] mspec [$];
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [5:0] p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("alloc_ready", int'(e.tag), 32'(u_if.alloc_ready_o), 32'(e.rdy));
      check("free_count", int'(e.tag), 32'(u_if.free_count_o), 32'(e.cnt));
      if (e.chk_p[0]) check("preg_slot0", int'(e.tag), 32'(u_if.alloc_preg_o[0]), 32'(e.p0));
      if (e.chk_p[1]) check("preg_slot1", int'(e.tag), 32'(u_if.alloc_preg_o[1]), 32'(e.p1));
    end
    if (!a_rst_n) begin
      for (int i = 0; i < PHY; i++) mown[i] = (i < ARCH);
      mspec.delete();
    end else begin
      for (int j = 0; j < CW; j++) begin
        if (u_if.commit_valid_i[j]) begin
          mown[u_if.commit_preg_i[j]] = 1'b0;
          if (mspec.size() > 0) void'(mspec.pop_front());
        end
      end
      if (u_if.alloc_ready_o) begin
        for (int i = 0; i < AW; i++) begin
          if (u_if.alloc_valid_i[i]) begin
            p = u_if.alloc_preg_o[i];
            check("preg_unique", tag, 32'(mown[p]), 32'd0);
            mown[p] = 1'b1;
            mspec.push_back(p);
          end
        end
      end
      if (u_if.flush_i) begin
        foreach (mspec[k]) mown[mspec[k]] = 1'b0;
        mspec.delete();
      end
    end
  end

  task automatic model_reset();
    fq.delete(); sq.delete(); mapped.delete();
    for (int i = 0; i < ARCH; i++) begin
      mapped.push_back(6'(i));
      fq.push_back(6'(ARCH + i));
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    a_rst_n = 1'b0;
    u_if.alloc_valid_i = 2'b11; u_if.commit_valid_i = 2'b00; u_if.flush_i = 1'b0;
    model_reset();
    tag++;
    e = '{tag: 16'(tag), rdy: 1'b1, chk_p: 2'b11, p1: 6'd33, p0: 6'd32, cnt: 6'd32};
    exp_q.push_back(e);
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    u_if.alloc_valid_i = 2'b00;
  endtask

  task automatic step(input logic [1:0] av, input logic [1:0] cv, input logic [5:0] c0, input logic [5:0] c1,
                      input logic fl, input bit hand, input logic hr, input logic [5:0] hp0,
                      input logic [5:0] hp1, input logic [5:0] hc);
    exp_t       e;
    logic       mrdy;
    logic [5:0] mp [2];
    int         k;
    @(posedge clk); #1;
    u_if.alloc_valid_i  = av;
    u_if.commit_valid_i = cv;
    u_if.commit_preg_i  = {c1, c0};
    u_if.flush_i        = fl;
    tag++;
    mrdy = (fq.size() >= AW) && !fl;
    mp[0] = '0; mp[1] = '0; k = 0;
    for (int i = 0; i < AW; i++) begin
      if (av[i]) begin
        if (k < fq.size()) mp[i] = fq[k];
        k++;
      end
    end
    e.tag   = 16'(tag);
    e.rdy   = hand ? hr : mrdy;
    e.cnt   = hand ? hc : 6'(fq.size());
    e.chk_p = (hand ? hr : mrdy) ? av : 2'b00;
    e.p0    = hand ? hp0 : mp[0];
    e.p1    = hand ? hp1 : mp[1];
    exp_q.push_back(e);
    repeat ($countones(cv)) if (sq.size() > 0) void'(sq.pop_front());
    if (mrdy && |av) for (int i = 0; i < AW; i++) if (av[i]) sq.push_back(fq.pop_front());
    if (cv[0]) fq.push_back(c0);
    if (cv[1]) fq.push_back(c1);
    if (fl) begin
      for (int i = sq.size() - 1; i >= 0; i--) fq.push_front(sq[i]);
      sq.delete();
    end
  endtask

  task automatic d(input logic [1:0] av, input logic [1:0] cv, input logic [5:0] c0, input logic [5:0] c1,
                   input logic fl, input logic hr, input logic [5:0] hp0, input logic [5:0] hp1, input logic [5:0] hc);
    step(av, cv, c0, c1, fl, 1'b1, hr, hp0, hp1, hc);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0] av, cv, cvr;
    logic [5:0] c [2];
    logic       fl;
    int         used;
    u_if.alloc_valid_i  = '0;
    u_if.commit_valid_i = '0;
    u_if.commit_preg_i  = '0;
    u_if.flush_i        = 1'b0;

    // Reset values and first grant.
    do_reset();
    d(2'b11, 2'b00, 0, 0, 0, 1, 32, 33, 32);
    d(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 30);

    // Compaction: lone slot1 request takes the head entry.
    do_reset();
    d(2'b10, 2'b00, 0, 0, 0, 1, 0, 32, 32);
    d(2'b11, 2'b00, 0, 0, 0, 1, 33, 34, 31);
    d(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 29);

    // Drain to empty, then refill through commit.
    do_reset();
    for (int k = 0; k < 16; k++) d(2'b11, 2'b00, 0, 0, 0, 1, 6'(32 + 2*k), 6'(33 + 2*k), 6'(32 - 2*k));
    d(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    d(2'b00, 2'b11, 5, 7, 0, 0, 0, 0, 0);
    d(2'b11, 2'b00, 0, 0, 0, 1, 5, 7, 2);
    d(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // Flush returns squashed grants in original order.
    do_reset();
    d(2'b11, 2'b00, 0, 0, 0, 1, 32, 33, 32);
    d(2'b11, 2'b00, 0, 0, 0, 1, 34, 35, 30);
    d(2'b11, 2'b00, 0, 0, 0, 1, 36, 37, 28);
    d(2'b00, 2'b11, 0, 1, 0, 1, 0, 0, 26);
    d(2'b11, 2'b00, 0, 0, 1, 0, 0, 0, 28);
    d(2'b11, 2'b00, 0, 0, 0, 1, 34, 35, 32);
    d(2'b11, 2'b00, 0, 0, 0, 1, 36, 37, 30);
    d(2'b11, 2'b00, 0, 0, 0, 1, 38, 39, 28);

    // Alloc and commit in the same cycle at count == 2: no bypass.
    do_reset();
    for (int k = 0; k < 15; k++) d(2'b11, 2'b00, 0, 0, 0, 1, 6'(32 + 2*k), 6'(33 + 2*k), 6'(32 - 2*k));
    d(2'b11, 2'b11, 8, 9, 0, 1, 62, 63, 2);
    d(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 2);
    d(2'b11, 2'b00, 0, 0, 0, 1, 8, 9, 2);

    // Random alloc/commit/flush with a mid-run asynchronous reset.
    do_reset();
    for (int n = 0; n < 100; n++) begin
      if (n == 50) begin
        do_reset();
        d(2'b11, 2'b00, 0, 0, 0, 1, 32, 33, 32);
        d(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 30);
      end
      av   = 2'($urandom_range(0, 3));
      cvr  = 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 9) == 0);
      cv   = 2'b00; c[0] = '0; c[1] = '0; used = 0;
      for (int j = 0; j < CW; j++) begin
        if (cvr[j] && used < sq.size()) begin
          cv[j] = 1'b1;
          mapped.push_back(sq[used]);
          c[j] = mapped.pop_front();
          used++;
        end
      end
      step(av, cv, c[0], c[1], fl, 1'b0, 1'b0, 0, 0, 0);
    end

    @(posedge clk); #1;
    u_if.alloc_valid_i = '0; u_if.commit_valid_i = '0; u_if.flush_i = 1'b0;
    @(negedge clk); #1;
    check("queue_drained", tag, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
